// File: rtl/regfile_2w4r_trace_pkg.sv
// regfile_2w4r_trace_pkg: shared bus layout and trace entry type for the dual-write register file
package regfile_2w4r_trace_pkg;
  localparam int WS_TO_RF_BUS_WD = 76;
  localparam int RF_TRACE_ENTRY_WD = 69;
  localparam int WDATA1_LSB = 0;
  localparam int WADDR1_LSB = 32;
  localparam int WE1_BIT = 37;
  localparam int WDATA2_LSB = 38;
  localparam int WADDR2_LSB = 70;
  localparam int WE2_BIT = 75;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0] wnum;
    logic [31:0] wdata;
  } rf_trace_entry_t;
endpackage

// File: rtl/regfile_2w4r_trace_fifo.sv
// trace_fifo_2w1r: circular queue taking up to two entries per cycle and draining one whenever non-empty
module trace_fifo_2w1r
  import regfile_2w4r_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push1,
  input  rf_trace_entry_t d1,
  input  logic push2,
  input  rf_trace_entry_t d2,
  output logic pop,
  output rf_trace_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  rf_trace_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign pop = count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push1) + PW'(push2);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push1) + CW'(push2) - CW'(pop);
    end
  end
  // a lone port-2 push takes the first free slot so ordering stays oldest-first
  always_ff @(posedge clk) begin
    if (push1 | push2) mem[wr_ptr] <= push1 ? d1 : d2;
    if (push1 & push2) mem[wr_ptr + 1'b1] <= d2;
  end
endmodule

// File: rtl/regfile_2w4r_trace.sv
// regfile_2w4r_trace: 32x32 GPR file with two write ports, four read ports and a serialized writeback trace
module regfile_2w4r_trace
  import regfile_2w4r_trace_pkg::*;
#(
  parameter int TRACE_DEPTH = 4,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [31:0] ws_pc1,
  input  logic [31:0] ws_pc2,
  output logic rf_accept,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  input  logic [4:0] raddr3,
  input  logic [4:0] raddr4,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] rdata3,
  output logic [31:0] rdata4,
  output logic [31:0] debug_wb_pc,
  output logic [3:0] debug_wb_rf_wen,
  output logic [4:0] debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic trace_empty
);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;
  logic we1, we2, eff1, eff2, pop;
  logic [4:0] waddr1, waddr2;
  logic [31:0] wdata1, wdata2;
  logic [CW-1:0] count;
  logic [31:0] rf [32];
  logic [4:0] raddr [4];
  logic [31:0] rdata [4];
  rf_trace_entry_t head;
  assign we1 = ws_to_rf_bus[WE1_BIT];
  assign we2 = ws_to_rf_bus[WE2_BIT];
  assign waddr1 = ws_to_rf_bus[WADDR1_LSB +: 5];
  assign waddr2 = ws_to_rf_bus[WADDR2_LSB +: 5];
  assign wdata1 = ws_to_rf_bus[WDATA1_LSB +: 32];
  assign wdata2 = ws_to_rf_bus[WDATA2_LSB +: 32];
  // room for a dual write is demanded regardless of how many writes are actually pending
  assign rf_accept = !reset && (count <= CW'(TRACE_DEPTH - 2));
  assign eff1 = we1 && rf_accept && waddr1 != '0;
  assign eff2 = we2 && rf_accept && waddr2 != '0;
  assign trace_empty = count == '0;
  assign raddr = '{raddr1, raddr2, raddr3, raddr4};
  always_comb begin
    for (int i = 0; i < 4; i++)
      rdata[i] = raddr[i] == '0 ? '0 :
                 (BYPASS != 0 && eff2 && waddr2 == raddr[i]) ? wdata2 :
                 (BYPASS != 0 && eff1 && waddr1 == raddr[i]) ? wdata1 : rf[raddr[i]];
  end
  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];
  assign rdata3 = rdata[2];
  assign rdata4 = rdata[3];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (eff1) rf[waddr1] <= wdata1;
      if (eff2) rf[waddr2] <= wdata2;
    end
  end
  trace_fifo_2w1r #(.DEPTH(TRACE_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push1(eff1),
    .d1('{pc: ws_pc1, wnum: waddr1, wdata: wdata1}),
    .push2(eff2),
    .d2('{pc: ws_pc2, wnum: waddr2, wdata: wdata2}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      debug_wb_pc <= '0;
      debug_wb_rf_wen <= '0;
      debug_wb_rf_wnum <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_rf_wen <= pop ? 4'hf : 4'h0;
      if (pop) begin
        debug_wb_pc <= head.pc;
        debug_wb_rf_wnum <= head.wnum;
        debug_wb_rf_wdata <= head.wdata;
      end
    end
  end
endmodule

// File: tb/tb_regfile_2w4r_trace.sv
// tb_regfile_2w4r_trace: random and directed writeback traffic checked against an array-plus-queue reference
module tb_regfile_2w4r_trace;
  logic clk = 1'b0;
  logic reset;
  logic [75:0] bus;
  logic [31:0] pc1, pc2;
  logic [4:0] ra [4];
  logic [31:0] rd [4];
  logic [31:0] rd0 [4];
  logic acc, acc0, empty, empty0;
  logic [31:0] dpc, dpc0, ddata, ddata0;
  logic [3:0] dwen, dwen0;
  logic [4:0] dnum, dnum0;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_rf [32];
  logic [68:0] q [$];
  logic [68:0] exp_entry;
  logic [3:0] exp_wen;
  logic m_acc;
  logic [4:0] prev_a1;

  always #5 clk = ~clk;

  regfile_2w4r_trace #(.TRACE_DEPTH(4), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ws_to_rf_bus(bus), .ws_pc1(pc1), .ws_pc2(pc2),
    .rf_accept(acc),
    .raddr1(ra[0]), .raddr2(ra[1]), .raddr3(ra[2]), .raddr4(ra[3]),
    .rdata1(rd[0]), .rdata2(rd[1]), .rdata3(rd[2]), .rdata4(rd[3]),
    .debug_wb_pc(dpc), .debug_wb_rf_wen(dwen), .debug_wb_rf_wnum(dnum),
    .debug_wb_rf_wdata(ddata), .trace_empty(empty)
  );

  regfile_2w4r_trace #(.TRACE_DEPTH(4), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .ws_to_rf_bus(bus), .ws_pc1(pc1), .ws_pc2(pc2),
    .rf_accept(acc0),
    .raddr1(ra[0]), .raddr2(ra[1]), .raddr3(ra[2]), .raddr4(ra[3]),
    .rdata1(rd0[0]), .rdata2(rd0[1]), .rdata3(rd0[2]), .rdata4(rd0[3]),
    .debug_wb_pc(dpc0), .debug_wb_rf_wen(dwen0), .debug_wb_rf_wnum(dnum0),
    .debug_wb_rf_wdata(ddata0), .trace_empty(empty0)
  );

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [31:0] p1, input logic w2, input logic [4:0] a2,
                      input logic [31:0] d2, input logic [31:0] p2);
    logic e1, e2, a;
    logic [31:0] er;
    reset = rst;
    bus = {w2, a2, d2, w1, a1, d1};
    pc1 = p1;
    pc2 = p2;
    ra[0] = a1;
    ra[1] = a2;
    ra[2] = prev_a1;
    ra[3] = 5'($urandom_range(0, 31));
    #1;
    a = !rst && (4 - q.size() >= 2);
    e1 = w1 && a && a1 != 0;
    e2 = w2 && a && a2 != 0;
    m_acc = a;
    check("rf_accept", acc, a);
    check("rf_accept_nobypass", acc0, a);
    check("trace_empty", empty, q.size() == 0);
    for (int i = 0; i < 4; i++) begin
      er = ra[i] == 0 ? 32'h0 : (e2 && a2 == ra[i]) ? d2 : (e1 && a1 == ra[i]) ? d1 : m_rf[ra[i]];
      check($sformatf("rdata%0d r%0d", i + 1, ra[i]), rd[i], er);
      check($sformatf("rdata%0d_nobypass r%0d", i + 1, ra[i]), rd0[i], ra[i] == 0 ? 32'h0 : m_rf[ra[i]]);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      q.delete();
      exp_wen = '0;
      exp_entry = '0;
    end else begin
      if (q.size() > 0) begin
        exp_entry = q.pop_front();
        exp_wen = 4'hf;
      end else exp_wen = 4'h0;
      if (e1) begin
        m_rf[a1] = d1;
        q.push_back({p1, a1, d1});
      end
      if (e2) begin
        m_rf[a2] = d2;
        q.push_back({p2, a2, d2});
      end
    end
    prev_a1 = a1;
    #1;
    check("debug_wen", dwen, exp_wen);
    check("debug_entry", {dpc, dnum, ddata}, exp_entry);
    check("debug_wen_nobypass", dwen0, exp_wen);
    check("debug_entry_nobypass", {dpc0, dnum0, ddata0}, exp_entry);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic w1, w2;
    logic [4:0] a1, a2;
    logic [31:0] d1, d2, p1, p2;
    reset = 1'b1;
    bus = '0;
    pc1 = '0;
    pc2 = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    exp_wen = '0;
    exp_entry = '0;
    m_acc = 1'b0;
    prev_a1 = '0;
    @(posedge clk);
    #1;
    step(1, 1, 9, 32'h55, 32'h10, 1, 10, 32'h66, 32'h14);
    step(0, 1, 5, 32'h1234, 32'hbfc00000, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 3, 32'hA, 32'h100, 1, 4, 32'hB, 32'h104);
    idle(3);
    step(0, 1, 7, 32'h1, 32'h200, 1, 7, 32'h2, 32'h204);
    idle(3);
    step(0, 1, 0, 32'hFFFF, 32'h300, 0, 0, 0, 0);
    idle(2);
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || m_acc) begin
        a1 = 5'(2 * k + 1);
        a2 = 5'(2 * k + 2);
        d1 = $urandom;
        d2 = $urandom;
        p1 = 32'h400 + 32'(8 * k);
        p2 = p1 + 4;
      end
      step(0, 1, a1, d1, p1, 1, a2, d2, p2);
    end
    idle(8);
    check("drained_empty", empty, 1'b1);
    step(0, 1, 11, 32'hC1, 32'h500, 1, 12, 32'hC2, 32'h504);
    step(0, 1, 13, 32'hC3, 32'h508, 1, 14, 32'hC4, 32'h50c);
    check("queued_three", empty, 1'b0);
    step(1, 1, 15, 32'hC5, 32'h510, 1, 16, 32'hC6, 32'h514);
    idle(2);
    w1 = 0; w2 = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0; p1 = 0; p2 = 0;
    for (int c = 0; c < 600; c++) begin
      if (m_acc) begin
        w1 = $urandom_range(0, 3) != 0;
        w2 = $urandom_range(0, 2) != 0;
        a1 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
        a2 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
        d1 = $urandom;
        d2 = $urandom;
        p1 = $urandom;
        p2 = p1 + 4;
      end
      step($urandom_range(0, 59) == 0, w1, a1, d1, p1, w2, a2, d2, p2);
      if (c % 100 == 99) idle(6);
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
